// File: rtl/multi_impulse_recorder.sv
// rtl/multi_impulse_recorder.sv - multi-pass impulse-response capture engine
//
// Purpose:
//   Fires the impulse generator, waits for it to finish, skips a programmable
//   number of sample ticks, then records LENGTH samples per channel into an
//   external RAM. Up to MAX_PASSES passes are summed in place so downstream
//   logic can average by a right shift.
// Ports:
//   audio_clk, rst_n_in                  clock, asynchronous active-low reset
//   audio_trigger                        one-cycle sample-tick strobe
//   start_in, abort_in                   capture start / cancel pulses
//   delay_length                         ticks skipped after impulse_done_in
//   num_passes                           requested pass count (latched at start)
//   audio_in                             N_CH packed signed samples
//   impulse_done_in, impulse_fire_out    impulse generator handshake
//   mem_addr, mem_we, mem_wdata          RAM write/read address port
//   mem_rdata                            RAM read data, one cycle after mem_addr
//   busy_out, pass_out                   capture in progress, current pass index
//   impulse_recorded                     one-cycle pulse when all passes are done
//   overrun_err                          sticky: tick dropped while sequencer busy
module multi_impulse_recorder #(
  parameter int N_CH       = 2,
  parameter int WIDTH      = 16,
  parameter int LENGTH     = 48000,
  parameter int MAX_PASSES = 4,
  parameter int ACC_W      = WIDTH + $clog2(MAX_PASSES),
  parameter int ADDR_W     = $clog2(N_CH * LENGTH)
) (
  input  logic                          audio_clk,
  input  logic                          rst_n_in,
  input  logic                          audio_trigger,
  input  logic                          start_in,
  input  logic                          abort_in,
  input  logic [15:0]                   delay_length,
  input  logic [$clog2(MAX_PASSES):0]   num_passes,
  input  logic [N_CH*WIDTH-1:0]         audio_in,
  input  logic                          impulse_done_in,
  output logic                          impulse_fire_out,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [ACC_W-1:0]              mem_wdata,
  input  logic [ACC_W-1:0]              mem_rdata,
  output logic                          busy_out,
  output logic [$clog2(MAX_PASSES):0]   pass_out,
  output logic                          impulse_recorded,
  output logic                          overrun_err
);

  localparam int PW    = $clog2(MAX_PASSES) + 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  // Per-channel sequencer phases: present address, RAM read settles, write.
  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT_IMP,
    S_DELAY,
    S_RECORD,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          passes_q, passes_d;
  logic [PW-1:0]          pass_q, pass_d;
  logic [15:0]            dly_target_q, dly_target_d;
  logic [15:0]            dly_cnt_q, dly_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [1:0]             phase_q, phase_d;
  logic                   seq_busy_q, seq_busy_d;
  logic [N_CH*WIDTH-1:0]  samples_q, samples_d;
  logic                   overrun_q, overrun_d;

  logic signed [WIDTH-1:0] samp_cur;
  logic [ADDR_W-1:0]       addr_calc;

  assign samp_cur  = samples_q[int'(ch_q)*WIDTH +: WIDTH];
  assign addr_calc = ADDR_W'(ch_q) * ADDR_W'(LENGTH) + ADDR_W'(idx_q);

  assign busy_out    = (state_q != S_IDLE);
  assign pass_out    = pass_q;
  assign overrun_err = overrun_q;
  // Address is only meaningful while a channel is being processed; hold 0
  // otherwise so the port is quiet outside RECORD.
  assign mem_addr    = (state_q == S_RECORD && seq_busy_q) ? addr_calc : '0;

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      passes_q     <= '0;
      pass_q       <= '0;
      dly_target_q <= '0;
      dly_cnt_q    <= '0;
      idx_q        <= '0;
      ch_q         <= '0;
      phase_q      <= PH_A;
      seq_busy_q   <= 1'b0;
      samples_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      passes_q     <= passes_d;
      pass_q       <= pass_d;
      dly_target_q <= dly_target_d;
      dly_cnt_q    <= dly_cnt_d;
      idx_q        <= idx_d;
      ch_q         <= ch_d;
      phase_q      <= phase_d;
      seq_busy_q   <= seq_busy_d;
      samples_q    <= samples_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    passes_d         = passes_q;
    pass_d           = pass_q;
    dly_target_d     = dly_target_q;
    dly_cnt_d        = dly_cnt_q;
    idx_d            = idx_q;
    ch_d             = ch_q;
    phase_d          = phase_q;
    seq_busy_d       = seq_busy_q;
    samples_d        = samples_q;
    overrun_d        = overrun_q;
    impulse_fire_out = 1'b0;
    impulse_recorded = 1'b0;
    mem_we           = 1'b0;
    mem_wdata        = '0;

    case (state_q)
      S_IDLE: begin
        if (start_in && !abort_in) begin
          if (num_passes == '0) begin
            passes_d = PW'(1);
          end else if (num_passes > PW'(MAX_PASSES)) begin
            passes_d = PW'(MAX_PASSES);
          end else begin
            passes_d = num_passes;
          end
          pass_d    = '0;
          overrun_d = 1'b0;
          state_d   = S_FIRE;
        end
      end

      S_FIRE: begin
        impulse_fire_out = 1'b1;
        state_d          = S_WAIT_IMP;
      end

      S_WAIT_IMP: begin
        if (impulse_done_in) begin
          dly_target_d = delay_length;
          dly_cnt_d    = '0;
          state_d      = S_DELAY;
        end
      end

      S_DELAY: begin
        // The exit is taken the cycle after the last counted tick, so a tick
        // landing on the exit cycle belongs to neither DELAY nor RECORD.
        if (dly_cnt_q == dly_target_q) begin
          state_d    = S_RECORD;
          idx_d      = '0;
          ch_d       = '0;
          phase_d    = PH_A;
          seq_busy_d = 1'b0;
        end else if (audio_trigger) begin
          dly_cnt_d = dly_cnt_q + 16'd1;
        end
      end

      S_RECORD: begin
        if (audio_trigger) begin
          if (seq_busy_q) begin
            overrun_d = 1'b1;
          end else begin
            samples_d  = audio_in;
            seq_busy_d = 1'b1;
            ch_d       = '0;
            phase_d    = PH_A;
          end
        end
        if (seq_busy_q) begin
          case (phase_q)
            PH_A:    phase_d = PH_B;
            PH_B:    phase_d = PH_C;
            default: begin
              mem_we  = 1'b1;
              phase_d = PH_A;
              if (ch_q == CH_W'(N_CH - 1)) begin
                seq_busy_d = 1'b0;
                ch_d       = '0;
                if (idx_q == IDX_W'(LENGTH - 1)) begin
                  idx_d = '0;
                  if ((pass_q + PW'(1)) < passes_q) begin
                    pass_d  = pass_q + PW'(1);
                    state_d = S_FIRE;
                  end else begin
                    state_d = S_DONE;
                  end
                end else begin
                  idx_d = idx_q + IDX_W'(1);
                end
              end else begin
                ch_d = ch_q + CH_W'(1);
              end
            end
          endcase
        end
      end

      S_DONE: begin
        impulse_recorded = 1'b1;
        state_d          = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything decided above for this cycle.
    if (abort_in && state_q != S_IDLE) begin
      state_d          = S_IDLE;
      seq_busy_d       = 1'b0;
      mem_we           = 1'b0;
      impulse_recorded = 1'b0;
      impulse_fire_out = 1'b0;
    end

    // Pass 0 overwrites stale RAM contents; later passes accumulate.
    if (mem_we) begin
      mem_wdata = (pass_q == '0) ? ACC_W'(samp_cur) : mem_rdata + ACC_W'(samp_cur);
    end
  end

endmodule

// File: tb/tb_multi_impulse_recorder.sv
// tb/tb_multi_impulse_recorder.sv - directed self-checking bench for multi_impulse_recorder
module tb_multi_impulse_recorder;

  localparam int N_CH       = 2;
  localparam int WIDTH      = 16;
  localparam int LENGTH     = 8;
  localparam int MAX_PASSES = 4;
  localparam int ACC_W      = 18;
  localparam int ADDR_W     = 4;
  localparam int PW         = 3;

  logic                  audio_clk       = 1'b0;
  logic                  rst_n_in        = 1'b0;
  logic                  audio_trigger   = 1'b0;
  logic                  start_in        = 1'b0;
  logic                  abort_in        = 1'b0;
  logic                  impulse_done_in = 1'b0;
  logic [15:0]           delay_length    = '0;
  logic [PW-1:0]         num_passes      = '0;
  logic [N_CH*WIDTH-1:0] audio_in        = '0;
  logic                  impulse_fire_out;
  logic                  mem_we;
  logic                  busy_out;
  logic                  impulse_recorded;
  logic                  overrun_err;
  logic [ADDR_W-1:0]     mem_addr;
  logic [ACC_W-1:0]      mem_wdata;
  logic [ACC_W-1:0]      mem_rdata;
  logic [PW-1:0]         pass_out;

  logic [ACC_W-1:0]      ram [0:15];

  int errors     = 0;
  int checks     = 0;
  int fire_cnt   = 0;
  int rec_cnt    = 0;
  int we_cnt     = 0;
  int fires_seen = 0;

  multi_impulse_recorder #(
    .N_CH(N_CH), .WIDTH(WIDTH), .LENGTH(LENGTH), .MAX_PASSES(MAX_PASSES),
    .ACC_W(ACC_W), .ADDR_W(ADDR_W)
  ) dut (
    .audio_clk(audio_clk),
    .rst_n_in(rst_n_in),
    .audio_trigger(audio_trigger),
    .start_in(start_in),
    .abort_in(abort_in),
    .delay_length(delay_length),
    .num_passes(num_passes),
    .audio_in(audio_in),
    .impulse_done_in(impulse_done_in),
    .impulse_fire_out(impulse_fire_out),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy_out(busy_out),
    .pass_out(pass_out),
    .impulse_recorded(impulse_recorded),
    .overrun_err(overrun_err)
  );

  always #5 audio_clk = ~audio_clk;

  // Synchronous RAM, one-cycle read latency, read-before-write.
  always @(posedge audio_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always begin
    @(negedge audio_clk);
    #1;
    if (impulse_fire_out) fire_cnt = fire_cnt + 1;
    if (impulse_recorded) rec_cnt = rec_cnt + 1;
    if (mem_we) we_cnt = we_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge audio_clk);
  endtask

  task automatic check_ram(input string tag, input int idx, input int val);
    logic [ACC_W-1:0] e;
    e = ACC_W'(val);
    check_eq($sformatf("%s[%0d]", tag, idx), 32'(ram[idx]), 32'(e));
  endtask

  task automatic start_cap(input int np, input int dly);
    @(negedge audio_clk);
    fires_seen   = fire_cnt;
    num_passes   = PW'(np);
    delay_length = 16'(dly);
    start_in     = 1'b1;
    @(negedge audio_clk);
    start_in     = 1'b0;
  endtask

  task automatic fire_and_done();
    int n;
    n = 0;
    while (fire_cnt == fires_seen && n < 300) begin
      @(negedge audio_clk);
      n++;
    end
    check_eq("fire_seen", 32'(fire_cnt != fires_seen), 32'd1);
    fires_seen = fire_cnt;
    cyc(2);
    impulse_done_in = 1'b1;
    cyc(1);
    impulse_done_in = 1'b0;
    cyc(2);
  endtask

  task automatic send_tick(input int a, input int b, input int gap);
    audio_in      = {16'(b), 16'(a)};
    audio_trigger = 1'b1;
    @(negedge audio_clk);
    audio_trigger = 1'b0;
    cyc(gap - 1);
  endtask

  task automatic run_pass(input int dly, input int a0, input int da, input int b0, input int db);
    fire_and_done();
    for (int k = 0; k < dly + LENGTH; k++) send_tick(a0 + k * da, b0 + k * db, 16);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_out && n < 500) begin
      @(negedge audio_clk);
      n++;
    end
    check_eq(tag, 32'(busy_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, f0, w0;

    // Reset state
    cyc(2);
    #1;
    check_eq("rst_busy",     32'(busy_out),         32'd0);
    check_eq("rst_fire",     32'(impulse_fire_out), 32'd0);
    check_eq("rst_we",       32'(mem_we),           32'd0);
    check_eq("rst_rec",      32'(impulse_recorded), 32'd0);
    check_eq("rst_overrun",  32'(overrun_err),      32'd0);
    check_eq("rst_pass",     32'(pass_out),         32'd0);
    check_eq("rst_addr",     32'(mem_addr),         32'd0);
    check_eq("rst_wdata",    32'(mem_wdata),        32'd0);
    @(negedge audio_clk);
    rst_n_in = 1'b1;
    cyc(2);

    // Single pass, delay 3: ticks 0..2 skipped
    r0 = rec_cnt;
    start_cap(1, 3);
    check_eq("t1_busy", 32'(busy_out), 32'd1);
    run_pass(3, 0, 1, 0, -1);
    wait_idle("t1_idle");
    for (int i = 0; i < LENGTH; i++) begin
      check_ram("t1_ram", i, i + 3);
      check_ram("t1_ram", LENGTH + i, -(i + 3));
    end
    check_eq("t1_rec", 32'(rec_cnt - r0), 32'd1);

    // Four-pass averaging at full scale
    f0 = fire_cnt;
    r0 = rec_cnt;
    start_cap(4, 0);
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("t2_pass%0d", p), 32'(pass_out), 32'(p));
      run_pass(0, 32'h7FFF, 0, -32768, 0);
    end
    wait_idle("t2_idle");
    check_eq("t2_fires", 32'(fire_cnt - f0), 32'd4);
    check_eq("t2_rec",   32'(rec_cnt - r0),  32'd1);
    for (int i = 0; i < LENGTH; i++) begin
      check_ram("t2_ram", i, 32'h1FFFC);
      check_ram("t2_ram", LENGTH + i, -131072);
    end

    // delay_length=0, num_passes=0 treated as one pass
    f0 = fire_cnt;
    r0 = rec_cnt;
    start_cap(0, 0);
    run_pass(0, 50, 1, -50, -1);
    wait_idle("t3_idle");
    check_eq("t3_fires", 32'(fire_cnt - f0), 32'd1);
    check_eq("t3_rec",   32'(rec_cnt - r0),  32'd1);
    check_ram("t3_ram", 0, 50);
    check_ram("t3_ram", 7, 57);
    check_ram("t3_ram", 8, -50);
    check_ram("t3_ram", 15, -57);

    // num_passes above MAX_PASSES clamps to four passes
    f0 = fire_cnt;
    start_cap(7, 0);
    for (int p = 0; p < 4; p++) run_pass(0, 1, 0, 2, 0);
    wait_idle("tc_idle");
    check_eq("tc_fires", 32'(fire_cnt - f0), 32'd4);
    check_ram("tc_ram", 3, 4);
    check_ram("tc_ram", 11, 8);

    // Overrun: second tick 4 cycles after the first is dropped
    start_cap(1, 0);
    fire_and_done();
    send_tick(100, -100, 4);
    send_tick(999, -999, 16);
    for (int k = 1; k < LENGTH; k++) send_tick(100 + k, -100 - k, 16);
    wait_idle("t4_idle");
    check_eq("t4_overrun", 32'(overrun_err), 32'd1);
    for (int i = 0; i < LENGTH; i++) begin
      check_ram("t4_ram", i, 100 + i);
      check_ram("t4_ram", LENGTH + i, -100 - i);
    end
    start_cap(1, 0);
    check_eq("t4_clear", 32'(overrun_err), 32'd0);
    abort_in = 1'b1;
    @(negedge audio_clk);
    abort_in = 1'b0;
    #1;
    check_eq("t4_abort_idle", 32'(busy_out), 32'd0);

    // Abort in RECORD at idx 5 of pass 1, landing on a write cycle
    start_cap(2, 0);
    run_pass(0, 10, 0, -10, 0);
    fire_and_done();
    for (int k = 0; k < 5; k++) send_tick(1, -1, 16);
    check_eq("t5_pass", 32'(pass_out), 32'd1);
    audio_in      = {16'(-1), 16'(1)};
    audio_trigger = 1'b1;
    cyc(1);
    audio_trigger = 1'b0;
    cyc(2);
    w0 = we_cnt;
    r0 = rec_cnt;
    abort_in = 1'b1;
    #1;
    check_eq("t5_we_forced", 32'(mem_we), 32'd0);
    @(negedge audio_clk);
    abort_in = 1'b0;
    #1;
    check_eq("t5_busy", 32'(busy_out), 32'd0);
    for (int k = 0; k < 3; k++) send_tick(7, 7, 16);
    cyc(10);
    check_eq("t5_no_we",  32'(we_cnt - w0),  32'd0);
    check_eq("t5_no_rec", 32'(rec_cnt - r0), 32'd0);
    check_ram("t5_ram", 4, 11);
    check_ram("t5_ram", 12, -11);
    check_ram("t5_ram", 5, 10);
    check_ram("t5_ram", 13, -10);
    r0 = rec_cnt;
    start_cap(1, 3);
    run_pass(3, 0, 2, 0, -2);
    wait_idle("t5_restart_idle");
    check_eq("t5_restart_rec", 32'(rec_cnt - r0), 32'd1);
    check_ram("t5_restart_ram", 0, 6);
    check_ram("t5_restart_ram", 7, 20);
    check_ram("t5_restart_ram", 15, -20);

    // Asynchronous reset mid-RECORD, then start ignored while busy
    start_cap(2, 0);
    run_pass(0, 5, 0, 5, 0);
    fire_and_done();
    send_tick(1, 1, 16);
    send_tick(1, 1, 16);
    audio_trigger = 1'b1;
    cyc(1);
    audio_trigger = 1'b0;
    #1;
    check_eq("t6_addr_pre", 32'(mem_addr), 32'd2);
    check_eq("t6_pass_pre", 32'(pass_out), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("t6_rst_busy",    32'(busy_out),         32'd0);
    check_eq("t6_rst_pass",    32'(pass_out),         32'd0);
    check_eq("t6_rst_addr",    32'(mem_addr),         32'd0);
    check_eq("t6_rst_we",      32'(mem_we),           32'd0);
    check_eq("t6_rst_wdata",   32'(mem_wdata),        32'd0);
    check_eq("t6_rst_fire",    32'(impulse_fire_out), 32'd0);
    check_eq("t6_rst_rec",     32'(impulse_recorded), 32'd0);
    check_eq("t6_rst_overrun", 32'(overrun_err),      32'd0);
    @(negedge audio_clk);
    rst_n_in = 1'b1;
    cyc(2);
    start_cap(2, 0);
    run_pass(0, 0, 0, 0, 0);
    check_eq("t6_pass1", 32'(pass_out), 32'd1);
    f0 = fire_cnt;
    start_in   = 1'b1;
    num_passes = 3'd1;
    @(negedge audio_clk);
    start_in = 1'b0;
    cyc(5);
    check_eq("t6_ign_pass",  32'(pass_out),        32'd1);
    check_eq("t6_ign_busy",  32'(busy_out),        32'd1);
    check_eq("t6_ign_fires", 32'(fire_cnt - f0),   32'd0);
    abort_in = 1'b1;
    @(negedge audio_clk);
    abort_in = 1'b0;
    #1;
    check_eq("t6_final_idle", 32'(busy_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
